// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions for the ID/EX operand stage.
//   - ALU op-code constants (4-bit)
//   - fwd_sel_e: which source feeds a forwarded operand
//   - ex_ctrl_t: EX-stage control bundle carried towards EX/MEM
package pipe_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_NOT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = 6'b000000;

endpackage

// File: rtl/id_ex_operand_stage_forward_unit.sv
// forward_unit: picks the freshest value of one source register.
// Ports:
//   addr_i            register number being read
//   rf_data_i         value captured from the register file
//   exmem_*_i         EX/MEM write-back candidate (highest priority)
//   memwb_*_i         MEM/WB write-back candidate
//   data_o            selected operand value
//   sel_o             which source was selected
module forward_unit
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic [DATA_W-1:0] data_o,
  output fwd_sel_e          sel_o
);

  // Priority bypass select; register 0 is hard-wired and never bypassed.
  always_comb begin
    sel_o  = FWD_REG;
    data_o = rf_data_i;
    if (exmem_regwrite_i && (exmem_rd_i != {REG_AW{1'b0}}) && (exmem_rd_i == addr_i)) begin
      sel_o  = FWD_EXMEM;
      data_o = exmem_result_i;
    end else if (memwb_regwrite_i && (memwb_rd_i != {REG_AW{1'b0}}) && (memwb_rd_i == addr_i)) begin
      sel_o  = FWD_MEMWB;
      data_o = memwb_result_i;
    end else begin
      sel_o  = FWD_REG;
      data_o = rf_data_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding
// and local load-use bubble insertion.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_*                        decoded instruction from ID
//   stall, flush                hold / bubble the EX register
//   exmem_*, memwb_*            forwarding sources from later stages
//   alu_first, alu_second       forwarded ALU operands
//   alu_control, ex_*           registered op code, control and destination
//   ex_store_data               forwarded rt value for stores
//   load_use_hazard             combinational; upstream holds IF/ID
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        id_alucontrol,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_first,
  output logic [DATA_W-1:0] alu_second,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic [REG_AW-1:0] ex_dest,
  output logic              load_use_hazard
);

  ex_ctrl_t          ctrl_q,    ctrl_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0] dest_q,    dest_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [3:0]        aluctl_q,  aluctl_d;
  logic              alusrc_q,  alusrc_d;

  logic [DATA_W-1:0] rs_fwd_s, rt_fwd_s;
  fwd_sel_e          rs_sel_s, rt_sel_s;
  logic              hazard_s;

  // Load in EX whose destination is read by ID; suppressed while the
  // register is being held or flushed so only one bubble is ever inserted.
  always_comb begin
    hazard_s = 1'b0;
    if (!stall && !flush && ctrl_q.valid && ctrl_q.memread &&
        (dest_q != {REG_AW{1'b0}}) && id_valid) begin
      hazard_s = (id_uses_rs && (id_rs_addr == dest_q)) ||
                 (id_uses_rt && (id_rt_addr == dest_q));
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Next-state selection: flush > stall > load-use bubble > load.
  always_comb begin
    ctrl_d    = ctrl_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    dest_d    = dest_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    aluctl_d  = aluctl_q;
    alusrc_d  = alusrc_q;
    if (flush || (!stall && hazard_s)) begin
      ctrl_d    = EX_CTRL_BUBBLE;
      rs_addr_d = {REG_AW{1'b0}};
      rt_addr_d = {REG_AW{1'b0}};
      dest_d    = {REG_AW{1'b0}};
      rs_data_d = {DATA_W{1'b0}};
      rt_data_d = {DATA_W{1'b0}};
      imm_d     = {DATA_W{1'b0}};
      aluctl_d  = ALU_ADD;
      alusrc_d  = 1'b0;
    end else if (stall) begin
      ctrl_d = ctrl_q;
    end else begin
      ctrl_d    = '{valid: id_valid, regwrite: id_regwrite, memread: id_memread,
                    memwrite: id_memwrite, memtoreg: id_memtoreg, branch: id_branch};
      rs_addr_d = id_rs_addr;
      rt_addr_d = id_rt_addr;
      dest_d    = id_rd_addr;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      aluctl_d  = id_alucontrol;
      alusrc_d  = id_alusrc;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= EX_CTRL_BUBBLE;
      rs_addr_q <= {REG_AW{1'b0}};
      rt_addr_q <= {REG_AW{1'b0}};
      dest_q    <= {REG_AW{1'b0}};
      rs_data_q <= {DATA_W{1'b0}};
      rt_data_q <= {DATA_W{1'b0}};
      imm_q     <= {DATA_W{1'b0}};
      aluctl_q  <= ALU_ADD;
      alusrc_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      dest_q    <= dest_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      aluctl_q  <= aluctl_d;
      alusrc_q  <= alusrc_d;
    end
  end

  forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .addr_i(rs_addr_q), .rf_data_i(rs_data_q),
    .exmem_regwrite_i(exmem_regwrite), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
    .memwb_regwrite_i(memwb_regwrite), .memwb_rd_i(memwb_rd), .memwb_result_i(memwb_result),
    .data_o(rs_fwd_s), .sel_o(rs_sel_s)
  );

  forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .addr_i(rt_addr_q), .rf_data_i(rt_data_q),
    .exmem_regwrite_i(exmem_regwrite), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
    .memwb_regwrite_i(memwb_regwrite), .memwb_rd_i(memwb_rd), .memwb_result_i(memwb_result),
    .data_o(rt_fwd_s), .sel_o(rt_sel_s)
  );

  // Operand muxes: the register-file path comes straight from the EX
  // register, bypassed values come from the forwarding units.
  always_comb begin
    alu_first     = (rs_sel_s == FWD_REG) ? rs_data_q : rs_fwd_s;
    ex_store_data = (rt_sel_s == FWD_REG) ? rt_data_q : rt_fwd_s;
    if (alusrc_q) begin
      alu_second = imm_q;
    end else begin
      alu_second = ex_store_data;
    end
  end

  assign alu_control     = aluctl_q;
  assign ex_valid        = ctrl_q.valid;
  assign ex_regwrite     = ctrl_q.regwrite;
  assign ex_memread      = ctrl_q.memread;
  assign ex_memwrite     = ctrl_q.memwrite;
  assign ex_memtoreg     = ctrl_q.memtoreg;
  assign ex_branch       = ctrl_q.branch;
  assign ex_dest         = dest_q;
  assign load_use_hazard = hazard_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_uses_rs, id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_alucontrol;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
  logic        stall, flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_first, alu_second, ex_store_data;
  logic [3:0]  alu_control;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
  logic [4:0]  ex_dest;
  logic        load_use_hazard;

  logic [5:0]  ctl;
  assign ctl = {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alucontrol(id_alucontrol), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_branch(id_branch),
    .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_first(alu_first), .alu_second(alu_second), .alu_control(alu_control),
    .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
    .ex_dest(ex_dest), .load_use_hazard(load_use_hazard)
  );

  // advance one rising edge, then settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rd_addr = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
    id_alucontrol = 4'd0; id_alusrc = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    id_memtoreg = 1'b0; id_branch = 1'b0;
    stall = 1'b0; flush = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  // drive a valid ALU/load instruction into ID
  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic urs, input logic urt,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [3:0] op, input logic memread);
    id_valid = 1'b1; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = 32'd0; id_alucontrol = op; id_alusrc = 1'b0;
    id_regwrite = 1'b1; id_memread = memread; id_memwrite = 1'b0;
    id_memtoreg = memread; id_branch = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000000); end
    total++; if ({alu_first, alu_second, ex_store_data} !== 96'd0) begin bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", alu_first, alu_second, ex_store_data); end
    total++; if ({alu_control, ex_dest, load_use_hazard} !== 10'd0) begin bad++;
      $display("FAIL reset_misc got=%h/%h/%b exp=0", alu_control, ex_dest, load_use_hazard); end
  endtask

  task automatic test_basic_add();
    drive_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd5, 32'd7, 4'b0000, 1'b0);
    tick();
    clear_inputs();
    #1;
    total++; if (alu_first !== 32'd5) begin bad++; $display("FAIL add_first got=%h exp=%h", alu_first, 32'd5); end
    total++; if (alu_second !== 32'd7) begin bad++; $display("FAIL add_second got=%h exp=%h", alu_second, 32'd7); end
    total++; if (alu_control !== 4'b0000 || ex_dest !== 5'd3) begin bad++;
      $display("FAIL add_op_dest got=%b/%0d exp=0000/3", alu_control, ex_dest); end
    total++; if (ctl !== 6'b110000) begin bad++; $display("FAIL add_ctl got=%b exp=%b", ctl, 6'b110000); end
  endtask

  task automatic test_forwarding();
    drive_id(5'd4, 5'd4, 5'd6, 1'b1, 1'b1, 32'h11, 32'h22, 4'b0001, 1'b0);
    tick();
    clear_inputs();
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
    #1;
    total++; if (alu_first !== 32'hAA) begin bad++; $display("FAIL fwd_exmem got=%h exp=%h", alu_first, 32'hAA); end
    total++; if (alu_second !== 32'hAA) begin bad++; $display("FAIL fwd_exmem_rt got=%h exp=%h", alu_second, 32'hAA); end
    exmem_regwrite = 1'b0;
    #1;
    total++; if (alu_first !== 32'hBB) begin bad++; $display("FAIL fwd_memwb got=%h exp=%h", alu_first, 32'hBB); end
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    total++; if (alu_first !== 32'h11 || alu_second !== 32'h22) begin bad++;
      $display("FAIL fwd_r0 got=%h/%h exp=%h/%h", alu_first, alu_second, 32'h11, 32'h22); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    drive_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h4, 32'h0, 4'b0000, 1'b1); // lw r5
    tick();
    drive_id(5'd5, 5'd1, 5'd7, 1'b0, 1'b1, 32'h50, 32'h10, 4'b0011, 1'b0);
    #1;
    total++; if (load_use_hazard !== 1'b0) begin bad++; $display("FAIL lu_unused_src got=%b exp=0", load_use_hazard); end
    id_uses_rs = 1'b1;
    #1;
    total++; if (load_use_hazard !== 1'b1) begin bad++; $display("FAIL lu_detect got=%b exp=1", load_use_hazard); end
    stall = 1'b1;
    #1;
    total++; if (load_use_hazard !== 1'b0) begin bad++; $display("FAIL lu_stall_mask got=%b exp=0", load_use_hazard); end
    stall = 1'b0;
    tick();
    total++; if (ctl !== 6'b000000 || ex_dest !== 5'd0 || alu_control !== 4'd0) begin bad++;
      $display("FAIL lu_bubble got=%b/%0d/%b exp=000000/0/0000", ctl, ex_dest, alu_control); end
    total++; if (load_use_hazard !== 1'b0) begin bad++; $display("FAIL lu_once got=%b exp=0", load_use_hazard); end
    tick();
    total++; if (ctl !== 6'b110000 || ex_dest !== 5'd7 || alu_first !== 32'h50 || alu_control !== 4'b0011) begin bad++;
      $display("FAIL lu_load got=%b/%0d/%h/%b exp=110000/7/50/0011", ctl, ex_dest, alu_first, alu_control); end
    clear_inputs();
  endtask

  task automatic test_stall_flush();
    drive_id(5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 32'h100, 32'h200, 4'b0001, 1'b0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(5'd10 + 5'(i), 5'd11, 5'd12 + 5'(i), 1'b1, 1'b1, 32'h900 + 32'(i), 32'h77, 4'b0100, 1'b1);
      tick();
      total++; if (ex_dest !== 5'd9 || alu_control !== 4'b0001 || alu_first !== 32'h100 || ctl !== 6'b110000) begin bad++;
        $display("FAIL stall_hold%0d got=%0d/%b/%h/%b exp=9/0001/100/110000", i, ex_dest, alu_control, alu_first, ctl); end
    end
    flush = 1'b1;
    tick();
    total++; if (ctl !== 6'b000000 || ex_dest !== 5'd0 || alu_first !== 32'd0) begin bad++;
      $display("FAIL flush_over_stall got=%b/%0d/%h exp=000000/0/0", ctl, ex_dest, alu_first); end
    clear_inputs();
  endtask

  task automatic test_alusrc_store();
    drive_id(5'd0, 5'd8, 5'd0, 1'b1, 1'b1, 32'h0, 32'h55, 4'b0000, 1'b0);
    id_alusrc = 1'b1; id_imm = 32'hFFFF_FFF0; id_regwrite = 1'b0; id_memwrite = 1'b1;
    tick();
    clear_inputs();
    exmem_regwrite = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h1234;
    #1;
    total++; if (alu_second !== 32'hFFFF_FFF0) begin bad++; $display("FAIL imm_second got=%h exp=%h", alu_second, 32'hFFFF_FFF0); end
    total++; if (ex_store_data !== 32'h1234) begin bad++; $display("FAIL store_fwd got=%h exp=%h", ex_store_data, 32'h1234); end
    total++; if (ctl !== 6'b100100) begin bad++; $display("FAIL store_ctl got=%b exp=%b", ctl, 6'b100100); end
    clear_inputs();
  endtask

  task automatic test_reset_hazard();
    drive_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h4, 32'h0, 4'b0000, 1'b1);
    tick();
    drive_id(5'd5, 5'd1, 5'd7, 1'b1, 1'b1, 32'h50, 32'h10, 4'b0011, 1'b0);
    #1;
    total++; if (load_use_hazard !== 1'b1) begin bad++; $display("FAIL rh_detect got=%b exp=1", load_use_hazard); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (ctl !== 6'b000000 || ex_dest !== 5'd0 || alu_first !== 32'd0 || load_use_hazard !== 1'b0) begin bad++;
      $display("FAIL rh_clear got=%b/%0d/%h/%b exp=000000/0/0/0", ctl, ex_dest, alu_first, load_use_hazard); end
    tick();
    total++; if (ctl !== 6'b110000 || ex_dest !== 5'd7) begin bad++;
      $display("FAIL rh_no_pending got=%b/%0d exp=110000/7", ctl, ex_dest); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_alusrc_store();
    test_reset_hazard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register plus operand-forwarding logic; sits directly upstream of the ALU and supplies its first operand, second operand and 4-bit operation code. It also carries the EX-stage control bits towards EX/MEM. Hazard handling is local:
- load-use detection with bubble insertion;
- external stall (hold) and flush (bubble).

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr, id_rd_addr  in  5  source/destination register numbers (id_rd_addr already resolved rt/rd by decode)
- id_uses_rs, id_uses_rt  in  1  instruction reads that source
- id_rs_data, id_rt_data  in  32  register-file read data
- id_imm  in  32  sign-extended immediate
- id_alucontrol  in  4  ALU op (0000 add … 1000 slt)
- id_alusrc  in  1  1: second operand = immediate
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch  in  1  control bits
- stall  in  1  hold EX register
- flush  in  1  replace EX register with bubble
- exmem_regwrite  in  1; exmem_rd  in  5; exmem_result  in  32  EX/MEM forwarding source
- memwb_regwrite  in  1; memwb_rd  in  5; memwb_result  in  32  MEM/WB forwarding source
- alu_first, alu_second  out  32  ALU operands
- alu_control  out  4  registered op code
- ex_store_data  out  32  forwarded rt value for stores
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  out  1  registered control
- ex_dest  out  5  registered destination
- load_use_hazard  out  1  combinational; upstream must hold IF/ID this cycle

## Operation
Register update priority each rising edge:
1. rst: all fields cleared.
2. flush: bubble.
3. stall: hold.
4. load_use_hazard: bubble.
5. Otherwise load ID fields.

Bubble definition: ex_valid=0, all control bits 0, alu_control=0000, data/address fields 0.

Load-use hazard:
- Asserted when ex_valid & ex_memread & ex_dest≠0 & id_valid, and either:
  - id_uses_rs & id_rs_addr==ex_dest, or
  - id_uses_rt & id_rt_addr==ex_dest.
- Forced 0 while stall or flush is high.

Forwarding, evaluated independently for the registered rs and rt:
- EX/MEM selected if exmem_regwrite & exmem_rd≠0 & exmem_rd==addr.
- Otherwise MEM/WB selected if memwb_regwrite & memwb_rd≠0 & memwb_rd==addr.
- Otherwise the registered register-file value.
- EX/MEM wins over MEM/WB. Register 0 is never forwarded.

Outputs:
- alu_first = forwarded rs.
- alu_second = registered imm when alusrc=1, else forwarded rt.
- ex_store_data = forwarded rt regardless of alusrc.

## Timing
- Reset values: every output 0 (load_use_hazard 0 because ex_valid=0).
- ID→EX latency: 1 cycle. Forwarding muxes are combinational from registered state plus the exmem/memwb inputs, valid in the same cycle.
- load_use_hazard is combinational from ID inputs and registered EX state. Exactly one bubble is inserted per load-use pair.
- Stall and flush in the same cycle: flush wins.
- Reset asserted mid-stall or mid-hazard clears the register at the next edge; no bubble is pending afterwards.
- Forwarding during stall tracks the live exmem/memwb inputs, so held operands update if the later stages advance.

## Structure
Shared package `pipe_pkg` holds:
- ALU op constants: ALU_ADD=0000, ALU_SUB=0001, ALU_XOR=0010, ALU_OR=0011, ALU_AND=0100, ALU_NOT=0101, ALU_SLL=0110, ALU_SRL=0111, ALU_SLT=1000.
- Forward-select enum: FWD_REG, FWD_EXMEM, FWD_MEMWB.
- Packed struct ex_ctrl_t: valid, regwrite, memread, memwrite, memtoreg, branch.

One sub-module, `forward_unit`, is instantiated twice (rs, rt). Inputs: address, regfile value and both forwarding sources. Outputs: selected value and select code.

## Test plan
- Reset, then load add r3,r1,r2 with rs=5, rt=7 → next cycle alu_first=5, alu_second=7, alu_control=0000, ex_valid=1, ex_dest=3.
- EX has r4; exmem_rd=4 with result 0xAA and memwb_rd=4 with result 0xBB, both regwrite=1 → alu_first=0xAA. Drop exmem_regwrite → 0xBB. Set rd=0 → register-file value.
- EX holds lw r5; ID reads rs=5 → load_use_hazard=1; next cycle ex_valid=0 with all control 0; following cycle the ID instruction loads.
- stall=1 for 3 cycles with changing ID inputs → EX fields unchanged. flush=1 together with stall=1 → bubble.
- alusrc=1, imm=0xFFFFFFF0, rt forwarded from exmem=0x1234 → alu_second=0xFFFFFFF0, ex_store_data=0x1234.
- rst asserted while load_use_hazard=1 → all outputs 0 next cycle and load_use_hazard=0.
